memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data wins simultaneous requests; one IDLE cycle separates transactions.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              iread,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dread,
    input  logic              dwrite,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              wr_q,    wr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;

        case (state_q)
            IDLE: begin
                if (!halt) begin
                    if (dread || dwrite) begin
                        state_d = DATA;
                        addr_d  = daddr;
                        wr_d    = dwrite;
                        store_d = dwrite ? dstore : '0;
                    end else if (iread) begin
                        state_d = INSTR;
                        addr_d  = iaddr;
                        wr_d    = 1'b0;
                        store_d = '0;
                    end
                end
            end

            DATA: begin
                if (wr_q) begin
                    // A granted write cannot be withdrawn; it runs to ram_ready.
                    ram_wen   = 1'b1;
                    ram_addr  = addr_q;
                    ram_store = store_q;
                    if (ram_ready) begin
                        dhit    = dwrite;
                        state_d = IDLE;
                    end
                end else if (dread || dwrite) begin
                    ram_ren  = 1'b1;
                    ram_addr = addr_q;
                    if (ram_ready) begin
                        dhit    = 1'b1;
                        dload   = ram_load;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            INSTR: begin
                if (iread) begin
                    ram_ren  = 1'b1;
                    ram_addr = addr_q;
                    if (ram_ready) begin
                        ihit    = 1'b1;
                        iload   = ram_load;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Keep the latched request clean whenever we sit in IDLE.
        if (state_d == IDLE) begin
            addr_d  = '0;
            store_d = '0;
            wr_d    = 1'b0;
        end
    end

endmodule
